// File: rtl/multi_dataflow_engine_ctrl.sv
// -----------------------------------------------------------------------------
// multi_dataflow_engine_ctrl
//
// Engine-side responder to the accelerator control FSM. It takes the engine
// control bundle and returns the engine flags. It also gates the inStream0
// source into the dataflow kernel, buffers kernel results in a 2-entry output
// FIFO, and counts outStream0 handshakes up to the programmed beat limit.
//
// Ports
//   clk_i, rst_i                   clock, synchronous active-high reset
//   clear_i, enable_i, start_i     engine control (soft clear, enable, start)
//   cnt_limit_i                    outStream0 beats per job, latched on start
//   ready_o                        engine idle and startable
//   cnt_o                          outStream0 beats delivered in this job
//   done_o                         one-cycle pulse when the job completes
//   in_valid_i/in_ready_o/in_data_i         inStream0 from the streamer
//   k_in_valid_o/k_in_ready_i/k_in_data_o   stream into the kernel
//   k_out_valid_i/k_out_ready_o/k_out_data_i stream out of the kernel
//   out_valid_o/out_ready_i/out_data_o      outStream0 to the streamer
// -----------------------------------------------------------------------------
module multi_dataflow_engine_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  enable_i,
    input  logic                  start_i,
    input  logic [CNT_WIDTH-1:0]  cnt_limit_i,
    output logic                  ready_o,
    output logic [CNT_WIDTH-1:0]  cnt_o,
    output logic                  done_o,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    output logic                  k_in_valid_o,
    input  logic                  k_in_ready_i,
    output logic [DATA_WIDTH-1:0] k_in_data_o,
    input  logic                  k_out_valid_i,
    output logic                  k_out_ready_o,
    input  logic [DATA_WIDTH-1:0] k_out_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] out_data_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   limit_q, limit_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]   cnt_inc;

    logic [DATA_WIDTH-1:0]  fifo_mem [2];
    logic                   wr_ptr_q, rd_ptr_q;
    logic [1:0]             occ_q;

    logic                   soft_rst;
    logic                   run_en;
    logic                   fifo_full, fifo_empty;
    logic                   at_limit;
    logic                   push, pop;
    logic                   flush;

    // Reset and clear have the same effect on every register.
    assign soft_rst   = rst_i | clear_i;
    assign run_en     = (state_q == RUN) & enable_i;
    assign fifo_full  = (occ_q == 2'd2);
    assign fifo_empty = (occ_q == 2'd0);
    assign at_limit   = (cnt_q == limit_q);
    assign cnt_inc    = cnt_q + CNT_ONE;

    // Kernel backpressure depends only on registered occupancy, never on
    // out_ready_i, so the sink cannot form a combinational loop through here.
    assign k_out_ready_o = run_en & ~fifo_full;
    // Gating on the limit stops the counter from ever passing it.
    assign out_valid_o   = run_en & ~fifo_empty & ~at_limit;
    assign out_data_o    = out_valid_o ? fifo_mem[rd_ptr_q] : '0;

    assign push = k_out_valid_i & k_out_ready_o;
    assign pop  = out_valid_o & out_ready_i;

    // Input path is a pure passthrough while running and enabled.
    assign k_in_valid_o = run_en & in_valid_i;
    assign in_ready_o   = run_en & k_in_ready_i;
    assign k_in_data_o  = run_en ? in_data_i : '0;

    assign ready_o = (state_q == IDLE);
    assign done_o  = (state_q == DONE);
    assign cnt_o   = cnt_q;

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        limit_d = limit_q;
        cnt_d   = cnt_q;
        flush   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i && enable_i) begin
                    limit_d = cnt_limit_i;
                    cnt_d   = '0;
                    state_d = (cnt_limit_i == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (pop) begin
                    cnt_d = cnt_inc;
                    // Final beat: leftover kernel results are dropped on the
                    // same edge the job finishes.
                    if (cnt_inc == limit_q) begin
                        state_d = DONE;
                        flush   = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge inputs regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (soft_rst) begin
            state_q <= IDLE;
            limit_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            limit_q <= limit_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (soft_rst || flush) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            if (push) wr_ptr_q <= ~wr_ptr_q;
            if (pop)  rd_ptr_q <= ~rd_ptr_q;
            occ_q <= occ_q + {1'b0, push} - {1'b0, pop};
        end
    end

    // NOTE: the storage array has no reset; an entry is only read after it has
    // been written, and out_data_o is forced to zero whenever nothing is valid.
    always_ff @(posedge clk_i) begin
        if (push) fifo_mem[wr_ptr_q] <= k_out_data_i;
    end

endmodule

// File: tb/tb_multi_dataflow_engine_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multi_dataflow_engine_ctrl
//
// Self-checking bench. A driver process plays the streamer source, the kernel
// and the streamer sink; a monitor process on the falling edge compares every
// DUT output against a job-level reference model and pops expected outStream0
// data from a scoreboard queue on each out handshake.
// -----------------------------------------------------------------------------
module tb_multi_dataflow_engine_ctrl;

    localparam int DW = 32;
    localparam int CW = 32;

    logic          clk_i;
    logic          rst_i, clear_i, enable_i, start_i;
    logic [CW-1:0] cnt_limit_i;
    logic          ready_o, done_o;
    logic [CW-1:0] cnt_o;
    logic          in_valid_i, in_ready_o;
    logic [DW-1:0] in_data_i;
    logic          k_in_valid_o, k_in_ready_i;
    logic [DW-1:0] k_in_data_o;
    logic          k_out_valid_i, k_out_ready_o;
    logic [DW-1:0] k_out_data_i;
    logic          out_valid_o, out_ready_i;
    logic [DW-1:0] out_data_o;

    multi_dataflow_engine_ctrl #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .clear_i      (clear_i),
        .enable_i     (enable_i),
        .start_i      (start_i),
        .cnt_limit_i  (cnt_limit_i),
        .ready_o      (ready_o),
        .cnt_o        (cnt_o),
        .done_o       (done_o),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .in_data_i    (in_data_i),
        .k_in_valid_o (k_in_valid_o),
        .k_in_ready_i (k_in_ready_i),
        .k_in_data_o  (k_in_data_o),
        .k_out_valid_i(k_out_valid_i),
        .k_out_ready_o(k_out_ready_o),
        .k_out_data_i (k_out_data_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .out_data_o   (out_data_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: job phase (0 idle, 1 running, 2 done), beats delivered,
    // latched limit, beats buffered, beats accepted, and the scoreboard queue.
    int          m_phase  = 0;
    logic [CW-1:0] m_cnt  = '0;
    logic [CW-1:0] m_lim  = '0;
    int          m_occ    = 0;
    int          m_pushed = 0;
    logic [DW-1:0] exp_q[$];

    // Bookkeeping shared with the main sequence.
    int done_cnt  = 0;
    int job_pops  = 0;
    int cyc       = 0;
    int first_pop = 0;
    int last_pop  = 0;
    int kern_left = 0;
    bit kv_rand   = 1'b0;
    int or_mode   = 0;
    int pat       = 0;

    // Driver: kernel, source and sink, updated after the main sequence.
    initial begin
        k_out_valid_i = 1'b0;
        k_out_data_i  = '0;
        out_ready_i   = 1'b0;
        in_valid_i    = 1'b0;
        k_in_ready_i  = 1'b0;
        in_data_i     = '0;
        forever begin
            @(posedge clk_i);
            #2;
            k_out_valid_i = (kern_left > 0) && (!kv_rand || ($urandom_range(0, 1) != 0));
            k_out_data_i  = $urandom;
            case (or_mode)
                0:       out_ready_i = 1'b1;
                1:       out_ready_i = (pat % 4 == 0) || (pat % 4 == 3);
                default: out_ready_i = ($urandom_range(0, 1) != 0);
            endcase
            pat++;
            in_valid_i   = ($urandom_range(0, 1) != 0);
            k_in_ready_i = ($urandom_range(0, 1) != 0);
            in_data_i    = $urandom;
        end
    end

    // Monitor: compares outputs, pops scoreboard, then advances the model.
    always @(negedge clk_i) begin
        bit run_en;
        bit m_push, m_pop;
        cyc++;
        run_en = (m_phase == 1) && enable_i;
        check("ready_o",       ready_o,       m_phase == 0);
        check("done_o",        done_o,        m_phase == 2);
        check("cnt_o",         cnt_o,         m_cnt);
        check("k_out_ready_o", k_out_ready_o, run_en && (m_occ < 2));
        check("out_valid_o",   out_valid_o,   run_en && (m_occ > 0) && (m_cnt != m_lim));
        check("k_in_valid_o",  k_in_valid_o,  run_en ? in_valid_i : 1'b0);
        check("in_ready_o",    in_ready_o,    run_en ? k_in_ready_i : 1'b0);
        check("k_in_data_o",   k_in_data_o,   run_en ? in_data_i : '0);

        if (done_o) done_cnt++;
        if (out_valid_o && out_ready_i) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL out_data: unexpected beat %0h at %0t", out_data_o, $time);
            end else begin
                check("out_data", out_data_o, exp_q.pop_front());
            end
            if (job_pops == 0) first_pop = cyc;
            last_pop = cyc;
            job_pops++;
        end
        if (k_out_valid_i && k_out_ready_o && kern_left > 0) kern_left--;

        if (rst_i || clear_i) begin
            m_phase = 0;
            m_cnt   = '0;
            m_lim   = '0;
            m_occ   = 0;
            exp_q.delete();
        end else begin
            case (m_phase)
                0: begin
                    if (start_i && enable_i) begin
                        m_lim    = cnt_limit_i;
                        m_cnt    = '0;
                        m_occ    = 0;
                        m_pushed = 0;
                        exp_q.delete();
                        m_phase  = (cnt_limit_i == '0) ? 2 : 1;
                    end
                end
                1: begin
                    if (enable_i) begin
                        m_push = k_out_valid_i && (m_occ < 2);
                        m_pop  = (m_occ > 0) && (m_cnt != m_lim) && out_ready_i;
                        if (m_push) begin
                            // Only the first m_lim accepted beats ever leave.
                            if (m_pushed < int'(m_lim)) exp_q.push_back(k_out_data_i);
                            m_pushed++;
                            m_occ++;
                        end
                        if (m_pop) begin
                            m_occ--;
                            m_cnt++;
                            if (m_cnt == m_lim) begin
                                m_phase = 2;
                                m_occ   = 0;
                                check("sb_drained", 64'(exp_q.size()), 64'd0);
                            end
                        end
                    end
                end
                default: m_phase = 0;
            endcase
        end
    end

    int done_base = 0;

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic start_job(input logic [CW-1:0] lim);
        enable_i    = 1'b1;
        cnt_limit_i = lim;
        start_i     = 1'b1;
        done_base   = done_cnt;
        job_pops    = 0;
        tick(1);
        start_i     = 1'b0;
        cnt_limit_i = $urandom;   // later changes must not affect the job
    endtask

    task automatic wait_done(input int budget, input bit rnd);
        int t = 0;
        while (done_cnt == done_base && t < budget) begin
            if (rnd) begin
                enable_i = ($urandom_range(0, 3) != 0);
                start_i  = ($urandom_range(0, 3) == 0);
            end
            tick(1);
            t++;
        end
        enable_i = 1'b1;
        start_i  = 1'b0;
        if (done_cnt == done_base) begin
            n_checks++;
            n_errors++;
            $display("FAIL done_timeout: no done_o within %0d cycles", budget);
        end
    endtask

    task automatic wait_pops(input int n, input int budget);
        int t = 0;
        while (job_pops < n && t < budget) begin
            tick(1);
            t++;
        end
        if (job_pops < n) begin
            n_checks++;
            n_errors++;
            $display("FAIL pop_timeout: %0d pops, wanted %0d", job_pops, n);
        end
    endtask

    initial begin
        rst_i       = 1'b1;
        clear_i     = 1'b0;
        enable_i    = 1'b1;
        start_i     = 1'b0;
        cnt_limit_i = '0;
        tick(2);
        rst_i = 1'b0;
        tick(1);

        // limit 4, full throughput
        or_mode = 0; kv_rand = 1'b0; kern_left = 4;
        start_job(4);
        wait_done(50, 1'b0);
        check("t1_pops", job_pops, 4);
        check("t1_back_to_back", last_pop - first_pop, 3);
        tick(2);

        // start with enable low is ignored
        enable_i = 1'b0; start_i = 1'b1; cnt_limit_i = 5;
        tick(1);
        start_i = 1'b0; enable_i = 1'b1;
        tick(2);

        // limit 8, sink pattern 1,0,0,1
        or_mode = 1; kern_left = 8;
        start_job(8);
        wait_done(200, 1'b0);
        check("t2_pops", job_pops, 8);
        check("t2_cnt", cnt_o, 8);
        tick(2);

        // limit 0
        or_mode = 0; kern_left = 4;
        start_job(0);
        wait_done(5, 1'b0);
        check("t3_pops", job_pops, 0);
        kern_left = 0;
        tick(2);

        // limit 3, kernel offers 5
        or_mode = 2; kern_left = 5;
        start_job(3);
        wait_done(200, 1'b0);
        check("t4_pops", job_pops, 3);
        tick(1);
        check("t4_cnt_hold", cnt_o, 3);
        kern_left = 0;
        tick(2);

        // limit 6 with a 5-cycle enable stall
        or_mode = 0; kv_rand = 1'b1; kern_left = 6;
        start_job(6);
        wait_pops(2, 100);
        enable_i = 1'b0;
        tick(5);
        enable_i = 1'b1;
        wait_done(200, 1'b0);
        check("t5_pops", job_pops, 6);
        tick(1);
        check("t5_cnt", cnt_o, 6);
        tick(1);

        // limit 10 aborted by clear, then by reset; each followed by limit 2
        for (int k = 0; k < 2; k++) begin
            or_mode = 0; kv_rand = 1'b0; kern_left = 10;
            start_job(10);
            wait_pops(4, 100);
            if (k == 0) clear_i = 1'b1; else rst_i = 1'b1;
            tick(1);
            clear_i = 1'b0; rst_i = 1'b0; kern_left = 0;
            tick(3);
            check("abort_no_done", done_cnt, done_base);
            check("abort_cnt", cnt_o, 0);
            kern_left = 2;
            start_job(2);
            wait_done(50, 1'b0);
            check("after_abort_pops", job_pops, 2);
            tick(2);
        end

        // randomized jobs with enable drops and stray starts
        for (int j = 0; j < 8; j++) begin
            int lim;
            lim = $urandom_range(1, 12);
            or_mode = 2; kv_rand = 1'b1;
            kern_left = lim + $urandom_range(0, 3);
            start_job(CW'(lim));
            wait_done(600, 1'b1);
            check("rand_pops", job_pops, lim);
            kern_left = 0;
            tick($urandom_range(1, 3));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
